// File: rtl/zeroriscy_mem_arbiter.sv
// Single-port SRAM arbiter between zeroriscy fetch and LSU ports.
// Optional ARB_STATS_EN adds grant/conflict counters.
module zeroriscy_mem_arbiter #(
  parameter int MEM_AW     = 10,
  parameter int RR_EN_P    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_igrant_o,
  output logic [31:0]       stat_dgrant_o,
  output logic [31:0]       stat_conflict_o
`endif
);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_I,
    RESP_D
  } resp_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       RR_EN      = (RR_EN_P != 0);

  resp_e      resp_q, resp_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       last_data_q, last_data_d;
  logic       both_req, pick_instr, gnt_i, gnt_d;

  logic unused_addr;
  assign unused_addr = ^{instr_addr_i[31:MEM_AW+2], instr_addr_i[1:0],
                         data_addr_i[31:MEM_AW+2], data_addr_i[1:0]};

  always_comb begin
    both_req   = instr_req_i & data_req_i;
    // last_data_q=1 means data won last; RR then favours fetch
    pick_instr = (instr_req_i & ~data_req_i) |
                 (both_req & ((starve_cnt_q == STARVE_LIM) |
                              (RR_EN & last_data_q)));
    gnt_i = pick_instr & ~rst_i;
    gnt_d = data_req_i & ~pick_instr & ~rst_i;

    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_i) begin
      mem_en_o   = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i[MEM_AW+1:2];
    end else if (gnt_d) begin
      mem_en_o    = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i[MEM_AW+1:2];
      mem_wdata_o = data_wdata_i;
    end

    starve_cnt_d = starve_cnt_q;
    if (!instr_req_i || gnt_i) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    last_data_d = last_data_q;
    if (gnt_i) begin
      last_data_d = 1'b0;
    end else if (gnt_d) begin
      last_data_d = 1'b1;
    end

    resp_d = RESP_NONE;
    if (gnt_i) begin
      resp_d = RESP_I;
    end else if (gnt_d) begin
      resp_d = RESP_D;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q       <= RESP_NONE;
      starve_cnt_q <= 4'd0;
      last_data_q  <= 1'b1;
    end else begin
      resp_q       <= resp_d;
      starve_cnt_q <= starve_cnt_d;
      last_data_q  <= last_data_d;
    end
  end

  assign instr_gnt_o    = gnt_i;
  assign data_gnt_o     = gnt_d;
  assign instr_rvalid_o = (resp_q == RESP_I);
  assign data_rvalid_o  = (resp_q == RESP_D);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

`ifdef ARB_STATS_EN
  logic [31:0] igrant_q, igrant_d;
  logic [31:0] dgrant_q, dgrant_d;
  logic [31:0] conflict_q, conflict_d;

  always_comb begin
    igrant_d   = igrant_q + {31'd0, gnt_i};
    dgrant_d   = dgrant_q + {31'd0, gnt_d};
    conflict_d = conflict_q + {31'd0, both_req};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      igrant_q   <= '0;
      dgrant_q   <= '0;
      conflict_q <= '0;
    end else begin
      igrant_q   <= igrant_d;
      dgrant_q   <= dgrant_d;
      conflict_q <= conflict_d;
    end
  end

  assign stat_igrant_o   = igrant_q;
  assign stat_dgrant_o   = dgrant_q;
  assign stat_conflict_o = conflict_q;
`endif

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// Directed bench for zeroriscy_mem_arbiter: fixed-priority and
// round-robin instances share stimulus.
module tb_zeroriscy_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] mem_rdata_i;

  logic        ig0, irv0, dg0, drv0, en0, we0;
  logic [31:0] ird0, drd0, wd0;
  logic [3:0]  be0;
  logic [9:0]  ad0;
  logic        ig1, irv1, dg1, drv1, en1, we1;
  logic [31:0] ird1, drd1, wd1;
  logic [3:0]  be1;
  logic [9:0]  ad1;
`ifdef ARB_STATS_EN
  logic [31:0] si0, sd0, sc0, si1, sd1, sc1;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  zeroriscy_mem_arbiter #(.MEM_AW(10), .RR_EN_P(0), .STARVE_MAX(4)) u0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(ig0), .instr_rvalid_o(irv0), .instr_rdata_o(ird0),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(dg0), .data_rvalid_o(drv0), .data_rdata_o(drd0),
    .mem_en_o(en0), .mem_we_o(we0), .mem_be_o(be0), .mem_addr_o(ad0),
    .mem_wdata_o(wd0), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_STATS_EN
    , .stat_igrant_o(si0), .stat_dgrant_o(sd0), .stat_conflict_o(sc0)
`endif
  );

  zeroriscy_mem_arbiter #(.MEM_AW(10), .RR_EN_P(1), .STARVE_MAX(4)) u1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(ig1), .instr_rvalid_o(irv1), .instr_rdata_o(ird1),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(dg1), .data_rvalid_o(drv1), .data_rdata_o(drd1),
    .mem_en_o(en1), .mem_we_o(we1), .mem_be_o(be1), .mem_addr_o(ad1),
    .mem_wdata_o(wd1), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_STATS_EN
    , .stat_igrant_o(si1), .stat_dgrant_o(sd1), .stat_conflict_o(sc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    data_we_i   = 1'b0;
    data_be_i   = 4'h0;
  endtask

  initial begin
    logic [5:0] exp0;
    logic [5:0] exp1;
    logic       p_i0, p_d0, p_i1, p_d1;
    exp0 = 6'b010000;
    exp1 = 6'b010101;

    rst_i        = 1'b1;
    instr_addr_i = 32'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    mem_rdata_i  = 32'h0;
    idle();
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    next_cycle();
    @(negedge clk_i);
    chk("rst_igNt", {31'd0, ig0}, 32'd0);
    chk("rst_dgnt", {31'd0, dg0}, 32'd0);
    chk("rst_en", {31'd0, en0}, 32'd0);
    chk("rst_irv", {31'd0, irv0}, 32'd0);
    chk("rst_drv", {31'd0, drv1}, 32'd0);

    next_cycle();
    rst_i = 1'b0;
    idle();
    @(negedge clk_i);
    chk("idle_en", {31'd0, en0}, 32'd0);
    chk("idle_we", {31'd0, we0}, 32'd0);
    chk("idle_be", {28'd0, be0}, 32'd0);
    chk("idle_irv", {31'd0, irv0}, 32'd0);

    // instruction fetch
    next_cycle();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0080;
    @(negedge clk_i);
    chk("t1_igNt", {31'd0, ig0}, 32'd1);
    chk("t1_dgnt", {31'd0, dg0}, 32'd0);
    chk("t1_en", {31'd0, en0}, 32'd1);
    chk("t1_addr", {22'd0, ad0}, 32'h20);
    chk("t1_be", {28'd0, be0}, 32'hF);
    chk("t1_we", {31'd0, we0}, 32'd0);
    next_cycle();
    idle();
    mem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    chk("t1_irv", {31'd0, irv0}, 32'd1);
    chk("t1_drv", {31'd0, drv0}, 32'd0);
    chk("t1_rdata", ird0, 32'h1234_5678);
    chk("t1_en_off", {31'd0, en0}, 32'd0);

    // data write
    next_cycle();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0011;
    data_addr_i  = 32'h0000_0104;
    data_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("t2_dgnt", {31'd0, dg0}, 32'd1);
    chk("t2_igNt", {31'd0, ig0}, 32'd0);
    chk("t2_we", {31'd0, we0}, 32'd1);
    chk("t2_addr", {22'd0, ad0}, 32'h41);
    chk("t2_be", {28'd0, be0}, 32'h3);
    chk("t2_wdata", wd0, 32'hDEAD_BEEF);
    // data read issued back-to-back
    next_cycle();
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h0000_0008;
    mem_rdata_i = 32'hCAFE_0001;
    @(negedge clk_i);
    chk("t2_drv", {31'd0, drv0}, 32'd1);
    chk("t2_irv", {31'd0, irv0}, 32'd0);
    chk("rd_dgnt", {31'd0, dg0}, 32'd1);
    chk("rd_we", {31'd0, we0}, 32'd0);
    chk("rd_addr", {22'd0, ad0}, 32'h2);
    chk("rd_drdata", drd0, 32'hCAFE_0001);

    // reset right after a data grant
    next_cycle();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_drv_pre", {31'd0, drv0}, 32'd1);
    chk("t5_gnt_rst", {31'd0, dg0}, 32'd0);
    chk("t5_en_rst", {31'd0, en0}, 32'd0);
    next_cycle();
    rst_i = 1'b0;
    idle();
    @(negedge clk_i);
    chk("t5_drv", {31'd0, drv0}, 32'd0);
    chk("t5_irv", {31'd0, irv0}, 32'd0);
    chk("t5_drv_rr", {31'd0, drv1}, 32'd0);

    // both ports requesting continuously
    instr_addr_i = 32'h0000_0040;
    data_addr_i  = 32'h0000_0200;
    p_i0 = 1'b0; p_d0 = 1'b0; p_i1 = 1'b0; p_d1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      instr_req_i = 1'b1;
      data_req_i  = 1'b1;
      data_be_i   = 4'hF;
      @(negedge clk_i);
      chk($sformatf("fp_ig%0d", i), {31'd0, ig0}, {31'd0, exp0[i]});
      chk($sformatf("fp_dg%0d", i), {31'd0, dg0}, {31'd0, ~exp0[i]});
      chk($sformatf("fp_ad%0d", i), {22'd0, ad0},
          exp0[i] ? 32'h10 : 32'h80);
      chk($sformatf("fp_irv%0d", i), {31'd0, irv0}, {31'd0, p_i0});
      chk($sformatf("fp_drv%0d", i), {31'd0, drv0}, {31'd0, p_d0});
      chk($sformatf("rr_ig%0d", i), {31'd0, ig1}, {31'd0, exp1[i]});
      chk($sformatf("rr_dg%0d", i), {31'd0, dg1}, {31'd0, ~exp1[i]});
      chk($sformatf("rr_irv%0d", i), {31'd0, irv1}, {31'd0, p_i1});
      chk($sformatf("rr_drv%0d", i), {31'd0, drv1}, {31'd0, p_d1});
      p_i0 = exp0[i]; p_d0 = ~exp0[i];
      p_i1 = exp1[i]; p_d1 = ~exp1[i];
    end
    next_cycle();
    idle();
    @(negedge clk_i);
    chk("end_drv0", {31'd0, drv0}, 32'd1);
    chk("end_drv1", {31'd0, drv1}, 32'd1);
    chk("end_en", {31'd0, en0}, 32'd0);
`ifdef ARB_STATS_EN
    chk("st_dgrant", sd0, 32'd5);
    chk("st_igrant", si0, 32'd1);
    chk("st_conflict", sc0, 32'd6);
    chk("st_rr_igrant", si1, 32'd3);
    chk("st_rr_dgrant", sd1, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
